// File: rtl/slice_window_stream.sv
// Registered ready/valid bit-window extractor: out_data = in_data[offset +: OUT_WIDTH], zero-filled.
// SCAN mode walks the window across one word. Define SLICE_WINDOW_STREAM_PARITY_EN for out_parity.
module slice_window_stream #(
  parameter int unsigned IN_WIDTH  = 10,
  parameter int unsigned OUT_WIDTH = 6,
  parameter int unsigned OFF_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [OFF_WIDTH-1:0] in_offset,
  input  logic                 in_scan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [OFF_WIDTH-1:0] out_offset,
  output logic                 out_last
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  localparam int unsigned MaxOff = IN_WIDTH - OUT_WIDTH;
  localparam logic [OFF_WIDTH-1:0] OffTop = '1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e               state_q;
  logic [IN_WIDTH-1:0]  word_q;
  logic [OFF_WIDTH-1:0] off_q;
  logic                 scan_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_last_q;
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
  logic                 out_parity_q;
`endif

  logic                 accept;
  logic [OFF_WIDTH-1:0] off_nxt;
  logic [OUT_WIDTH-1:0] load_win;
  logic [OUT_WIDTH-1:0] adv_win;

  // Logical right shift zero-fills, so bits past the top of the word read as 0 without wrap.
  function automatic logic [OUT_WIDTH-1:0] window_of(input logic [IN_WIDTH-1:0]  w,
                                                     input logic [OFF_WIDTH-1:0] o);
    logic [IN_WIDTH-1:0] sh;
    sh = w >> o;
    return sh[OUT_WIDTH-1:0];
  endfunction

  function automatic logic is_end(input logic [OFF_WIDTH-1:0] o, input logic s);
    return !s || (32'(o) >= MaxOff) || (o == OffTop);
  endfunction

  always_comb begin
    out_valid = (state_q == StEmit);
    in_ready  = !RESET && ((state_q == StIdle) || (out_ready && out_last_q));
    accept    = in_valid && in_ready;
    // Only used when out_last_q is 0, which rules out off_q at the top value.
    off_nxt   = off_q + OFF_WIDTH'(1);
    load_win  = window_of(in_data, in_offset);
    adv_win   = window_of(word_q, off_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      word_q       <= '0;
      off_q        <= '0;
      scan_q       <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q      <= StEmit;
      word_q       <= in_data;
      off_q        <= in_offset;
      scan_q       <= in_scan;
      out_data_q   <= load_win;
      out_last_q   <= is_end(in_offset, in_scan);
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
      out_parity_q <= ^load_win;
`endif
    end else if ((state_q == StEmit) && out_ready) begin
      if (out_last_q) begin
        state_q <= StIdle;
      end else begin
        off_q        <= off_nxt;
        out_data_q   <= adv_win;
        out_last_q   <= is_end(off_nxt, scan_q);
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
        out_parity_q <= ^adv_win;
`endif
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_offset = off_q;
  assign out_last   = out_last_q;
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_slice_window_stream.sv
// Bench for slice_window_stream: directed scenarios plus a randomized stream checked against
// a queue of expected windows computed arithmetically from each accepted word.
module tb_slice_window_stream;

  localparam int unsigned IW     = 10;
  localparam int unsigned OW     = 6;
  localparam int unsigned FW     = 3;
  localparam int unsigned MaxOff = IW - OW;
  localparam int unsigned OffTop = (1 << FW) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic [FW-1:0] in_offset = '0;
  logic          in_scan = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [FW-1:0] out_offset;
  logic          out_last;
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
  logic          out_parity;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OW-1:0] data;
    int unsigned   off;
    bit            last;
  } win_t;

  win_t        exp_q[$];
  bit          exp_rdy;
  int unsigned mon_off;
  bit          mon_done;
  win_t        mon_w;

  always #5 CLK = ~CLK;

  slice_window_stream #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .OFF_WIDTH(FW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_offset (in_offset),
    .in_scan   (in_scan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_offset(out_offset),
    .out_last  (out_last)
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  // Window = (W / 2^O) mod 2^OW; bits above the word are zero by construction.
  function automatic logic [OW-1:0] ref_window(input logic [IW-1:0] w, input int unsigned o);
    longint unsigned v;
    v = 64'(w);
    v = v / (64'd1 << o);
    v = v % (64'd1 << OW);
    return OW'(v);
  endfunction

  function automatic bit ref_last(input int unsigned o, input bit s);
    return !s || (o >= MaxOff) || (o == OffTop);
  endfunction

  // Scoreboard: every accepted word expands into its full list of windows up front.
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mon_reset_ready: in_ready=%b required 0", in_ready);
      end
      exp_q.delete();
    end else begin
      exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL mon_in_ready: in_ready=%b required %b", in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL mon_out_valid: out_valid=%b required %b", out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_data !== exp_q[0].data || out_offset !== FW'(exp_q[0].off) ||
            out_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL mon_window: data=%h off=%0d last=%b required data=%h off=%0d last=%b",
                   out_data, out_offset, out_last, exp_q[0].data, exp_q[0].off, exp_q[0].last);
        end
`ifdef SLICE_WINDOW_STREAM_PARITY_EN
        checks++;
        if (out_parity !== ^exp_q[0].data) begin
          errors++;
          $display("FAIL mon_parity: out_parity=%b required %b", out_parity, ^exp_q[0].data);
        end
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        mon_off  = in_offset;
        mon_done = 1'b0;
        while (!mon_done) begin
          mon_w.data = ref_window(in_data, mon_off);
          mon_w.off  = mon_off;
          mon_w.last = ref_last(mon_off, in_scan);
          exp_q.push_back(mon_w);
          mon_done = mon_w.last;
          mon_off++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    in_valid  = 1'b1;
    in_data   = IW'($urandom);
    in_offset = FW'($urandom);
    in_scan   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      end
      checks++;
      if (out_data !== '0 || out_last !== 1'b0 || out_offset !== '0) begin
        errors++;
        $display("FAIL reset_outputs: data=%h last=%b off=%0d required 0 0 0",
                 out_data, out_last, out_offset);
      end
    end
    tick();
    RESET    = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: out_valid=%b required 0", out_valid);
    end
    tick();
  endtask

  task automatic test_single();
    in_valid  = 1'b1;
    in_data   = 10'h2CE;
    in_offset = 3'd2;
    in_scan   = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'h33 || out_offset !== 3'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: valid=%b data=%h off=%0d last=%b required 1 33 2 1",
               out_valid, out_data, out_offset, out_last);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_beat: out_valid=%b required 0", out_valid);
    end
    tick();
  endtask

  task automatic test_scan();
    logic [OW-1:0] exp_d [5];
    exp_d[0] = 6'h0E;
    exp_d[1] = 6'h27;
    exp_d[2] = 6'h33;
    exp_d[3] = 6'h19;
    exp_d[4] = 6'h2C;
    in_valid  = 1'b1;
    in_data   = 10'h2CE;
    in_offset = 3'd0;
    in_scan   = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_offset !== FW'(k) ||
          out_last !== (k == 4) || in_ready !== (k == 4)) begin
        errors++;
        $display("FAIL scan_beat%0d: valid=%b data=%h off=%0d last=%b rdy=%b required 1 %h %0d %b %b",
                 k, out_valid, out_data, out_offset, out_last, in_ready,
                 exp_d[k], k, k == 4, k == 4);
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_end: out_valid=%b required 0", out_valid);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    in_valid  = 1'b1;
    in_data   = 10'h2CE;
    in_offset = 3'd6;
    in_scan   = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 6'h0B || out_offset !== 3'd6 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL oor_beat: valid=%b data=%h off=%0d last=%b required 1 0b 6 1",
               out_valid, out_data, out_offset, out_last);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_single: out_valid=%b required 0", out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit            pat [5];
    logic [IW-1:0] nd;
    logic [FW-1:0] no;
    logic [OW-1:0] ed;
    pat[0] = 1'b0;
    pat[1] = 1'b1;
    pat[2] = 1'b0;
    pat[3] = 1'b0;
    pat[4] = 1'b1;
    nd = IW'($urandom);
    no = FW'($urandom);
    in_valid  = 1'b1;
    in_data   = 10'h2CE;
    in_offset = 3'd3;
    in_scan   = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    tick();
    in_data   = nd;
    in_offset = no;
    in_scan   = 1'b0;
    out_ready = pat[0];
    for (int c = 0; c < 5; c++) begin
      ed = (c < 2) ? 6'h19 : 6'h2C;
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed || out_offset !== FW'((c < 2) ? 3 : 4) ||
          out_last !== (c >= 2) || in_ready !== (c == 4)) begin
        errors++;
        $display("FAIL bp_cycle%0d: valid=%b data=%h off=%0d last=%b rdy=%b required 1 %h %0d %b %b",
                 c, out_valid, out_data, out_offset, out_last, in_ready,
                 ed, (c < 2) ? 3 : 4, c >= 2, c == 4);
      end
      tick();
      if (c < 4) out_ready = pat[c+1];
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_window(nd, no) || out_offset !== no ||
        out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_word: valid=%b data=%h off=%0d last=%b required 1 %h %0d 1",
               out_valid, out_data, out_offset, out_last, ref_window(nd, no), no);
    end
    tick();
    @(negedge CLK);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] d [4];
    logic [FW-1:0] o [4];
    for (int w = 0; w < 4; w++) begin
      d[w] = IW'($urandom);
      o[w] = FW'($urandom);
    end
    out_ready = 1'b1;
    in_scan   = 1'b0;
    for (int w = 0; w < 4; w++) begin
      in_valid  = 1'b1;
      in_data   = d[w];
      in_offset = o[w];
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: in_ready=%b required 1", w, in_ready);
      end
      if (w > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref_window(d[w-1], o[w-1]) ||
            out_offset !== o[w-1]) begin
          errors++;
          $display("FAIL b2b_beat%0d: valid=%b data=%h off=%0d required 1 %h %0d",
                   w - 1, out_valid, out_data, out_offset, ref_window(d[w-1], o[w-1]), o[w-1]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_window(d[3], o[3]) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beat3: valid=%b data=%h last=%b required 1 %h 1",
               out_valid, out_data, out_last, ref_window(d[3], o[3]));
    end
    tick();
    @(negedge CLK);
    tick();
  endtask

  task automatic test_reset_mid_scan();
    in_valid  = 1'b1;
    in_data   = IW'($urandom);
    in_offset = 3'd0;
    in_scan   = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midscan_reset%0d: out_valid=%b required 0", k, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int sent;
    bit acc;
    sent = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 4000 && sent < 150; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid  = 1'b1;
        in_data   = IW'($urandom);
        in_offset = FW'($urandom);
        in_scan   = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    checks++;
    if (sent != 150) begin
      errors++;
      $display("FAIL random_progress: words accepted=%0d required 150", sent);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: out_valid=%b required 0", out_valid);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
